mem_lsu_rmw: RTL

//  Sequential load/store unit for the MEM stage. It takes one request at a time from EX.
//  It does offset-aware byte/half/word lane extraction with sign or zero extension.
//  Sub-word stores use read-modify-write when the memory has no byte enables.

---
 rtl/mem_lsu_rmw_pkg.sv | 41 ++++
 rtl/lsu_lane_align.sv | 62 ++++++
 rtl/mem_lsu_rmw.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_rmw_pkg.sv
// Shared definitions for the MEM-stage load/store unit: data type codes, FSM states,
// write-strobe constants and the access legality check.
package mem_lsu_rmw_pkg;

   localparam logic [2:0] DT_BYTE  = 3'd0;
   localparam logic [2:0] DT_HALF  = 3'd1;
   localparam logic [2:0] DT_WORD  = 3'd2;
   localparam logic [2:0] DT_UBYTE = 3'd3;
   localparam logic [2:0] DT_UHALF = 3'd4;

   localparam logic [31:0] DATA_ZERO     = 32'h0000_0000;
   localparam logic        WRITE_ENABLE  = 1'b1;
   localparam logic        WRITE_DISABLE = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE_RD = 3'd1,
      ST_WAIT     = 3'd2,
      ST_DATA     = 3'd3,
      ST_WB       = 3'd4,
      ST_WRITE    = 3'd5,
      ST_FAULT    = 3'd6
   } state_e;

   // Unsigned types are load-only; halves need even, words need 4-byte alignment.
   function automatic logic access_fault(input logic [2:0] dtype,
                                         input logic       store,
                                         input logic [1:0] off);
      logic bad;
      case (dtype)
         DT_BYTE:  bad = 1'b0;
         DT_HALF:  bad = off[0];
         DT_WORD:  bad = (off != 2'b00);
         DT_UBYTE: bad = store;
         DT_UHALF: bad = store | off[0];
         default:  bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load extraction/extension, store lane replication,
// byte-enable mask and the merged word used by read-modify-write stores.
module lsu_lane_align
   import mem_lsu_rmw_pkg::*;
(
   input  logic [2:0]  dtype,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] store_lanes,
   output logic [3:0]  be,
   output logic [31:0] merged
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      case (off)
         2'd0:    byte_lane = word[7:0];
         2'd1:    byte_lane = word[15:8];
         2'd2:    byte_lane = word[23:16];
         default: byte_lane = word[31:24];
      endcase
      half_lane = off[1] ? word[31:16] : word[15:0];

      case (dtype)
         DT_BYTE:  load_val = {{24{byte_lane[7]}}, byte_lane};
         DT_UBYTE: load_val = {24'h00_0000, byte_lane};
         DT_HALF:  load_val = {{16{half_lane[15]}}, half_lane};
         DT_UHALF: load_val = {16'h0000, half_lane};
         default:  load_val = word;
      endcase
   end

   always_comb begin
      case (dtype)
         DT_BYTE, DT_UBYTE: begin
            be          = 4'b0001 << off;
            store_lanes = {4{wdata[7:0]}};
         end
         DT_HALF, DT_UHALF: begin
            be          = off[1] ? 4'b1100 : 4'b0011;
            store_lanes = {2{wdata[15:0]}};
         end
         default: begin
            be          = 4'b1111;
            store_lanes = wdata;
         end
      endcase
   end

   // Only the enabled lanes take the new data; the rest keep the word read back.
   always_comb begin
      merged = DATA_ZERO;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = be[i] ? store_lanes[8*i +: 8] : word[8*i +: 8];
      end
   end

endmodule

// File: rtl/mem_lsu_rmw.sv
// MEM-stage load/store unit: one request at a time, sign/zero-extending loads,
// direct or read-modify-write sub-word stores, and fault reporting for bad accesses.
module mem_lsu_rmw
   import mem_lsu_rmw_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1,
   parameter int USE_BE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_store_i,
   input  logic [2:0]        req_type_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   input  logic [4:0]        req_rd_i,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   output logic              wb_valid_o,
   output logic [4:0]        wb_rd_o,
   output logic [31:0]       wb_data_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] err_addr_o
);

   localparam int CNT_W = $clog2(RD_LAT + 1);

   state_e state;
   state_e next_state;

   logic              store_q;
   logic [2:0]        type_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [4:0]        rd_q;
   logic [CNT_W-1:0]  cnt;

   logic              accept;
   logic              req_fault;
   logic              direct_write;
   logic [2:0]        cur_type;
   logic [ADDR_W-1:0] cur_addr;
   logic [31:0]       cur_wdata;
   logic [ADDR_W-1:0] word_addr;

   logic [31:0]       load_val;
   logic [31:0]       store_lanes;
   logic [3:0]        lane_be;
   logic [31:0]       merged;

   logic              ready_d;
   logic              en_d;
   logic              we_d;
   logic [3:0]        be_d;
   logic [ADDR_W-1:0] addr_d;
   logic [31:0]       wdata_d;
   logic              wb_valid_d;
   logic [4:0]        wb_rd_d;
   logic [31:0]       wb_data_d;
   logic              err_d;
   logic [ADDR_W-1:0] err_addr_d;

   assign accept       = (state == ST_IDLE) && req_valid_i;
   assign req_fault    = access_fault(req_type_i, req_store_i, req_addr_i[1:0]);
   assign direct_write = (req_type_i == DT_WORD) || (USE_BE != 0);

   // While idle the incoming request steers the datapath so the first cycle after acceptance is ready.
   assign cur_type  = (state == ST_IDLE) ? req_type_i  : type_q;
   assign cur_addr  = (state == ST_IDLE) ? req_addr_i  : addr_q;
   assign cur_wdata = (state == ST_IDLE) ? req_wdata_i : wdata_q;
   assign word_addr = {cur_addr[ADDR_W-1:2], 2'b00};

   lsu_lane_align u_align (
      .dtype       (cur_type),
      .off         (cur_addr[1:0]),
      .word        (mem_rdata_i),
      .wdata       (cur_wdata),
      .load_val    (load_val),
      .store_lanes (store_lanes),
      .be          (lane_be),
      .merged      (merged)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (req_valid_i) begin
               if (req_fault) begin
                  next_state = ST_FAULT;
               end else if (req_store_i && direct_write) begin
                  next_state = ST_WRITE;
               end else begin
                  next_state = ST_ISSUE_RD;
               end
            end
         end
         ST_ISSUE_RD: next_state = (RD_LAT == 1) ? ST_DATA : ST_WAIT;
         ST_WAIT:     next_state = (cnt == CNT_W'(1)) ? ST_DATA : ST_WAIT;
         ST_DATA:     next_state = store_q ? ST_WRITE : ST_WB;
         default:     next_state = ST_IDLE;
      endcase
   end

   // Next values for the registered outputs, keyed on the state being entered.
   always_comb begin
      ready_d    = (next_state == ST_IDLE);
      en_d       = 1'b0;
      we_d       = WRITE_DISABLE;
      be_d       = 4'b0000;
      addr_d     = mem_addr_o;
      wdata_d    = mem_wdata_o;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_o;
      wb_data_d  = wb_data_o;
      err_d      = 1'b0;
      err_addr_d = err_addr_o;
      case (next_state)
         ST_ISSUE_RD: begin
            en_d   = 1'b1;
            addr_d = word_addr;
         end
         ST_WRITE: begin
            en_d   = 1'b1;
            we_d   = WRITE_ENABLE;
            addr_d = word_addr;
            if (state == ST_DATA) begin
               be_d    = 4'hF;
               wdata_d = merged;
            end else begin
               be_d    = lane_be;
               wdata_d = store_lanes;
            end
         end
         ST_WB: begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = load_val;
         end
         ST_FAULT: begin
            err_d      = 1'b1;
            err_addr_d = cur_addr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready_o <= 1'b1;
         mem_en_o    <= 1'b0;
         mem_we_o    <= WRITE_DISABLE;
         mem_be_o    <= 4'b0000;
         mem_addr_o  <= '0;
         mem_wdata_o <= DATA_ZERO;
         wb_valid_o  <= 1'b0;
         wb_rd_o     <= 5'd0;
         wb_data_o   <= DATA_ZERO;
         err_o       <= 1'b0;
         err_addr_o  <= '0;
      end else begin
         req_ready_o <= ready_d;
         mem_en_o    <= en_d;
         mem_we_o    <= we_d;
         mem_be_o    <= be_d;
         mem_addr_o  <= addr_d;
         mem_wdata_o <= wdata_d;
         wb_valid_o  <= wb_valid_d;
         wb_rd_o     <= wb_rd_d;
         wb_data_o   <= wb_data_d;
         err_o       <= err_d;
         err_addr_o  <= err_addr_d;
      end
   end

   // Request context and the read-latency countdown, reloaded on every read issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         store_q <= 1'b0;
         type_q  <= DT_BYTE;
         addr_q  <= '0;
         wdata_q <= DATA_ZERO;
         rd_q    <= 5'd0;
         cnt     <= '0;
      end else begin
         if (accept) begin
            store_q <= req_store_i;
            type_q  <= req_type_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            rd_q    <= req_rd_i;
         end
         if (state == ST_ISSUE_RD) begin
            cnt <= CNT_W'(RD_LAT - 1);
         end else if (state == ST_WAIT) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

endmodule
